traffic_source: RTL and testbench
=================================

# traffic_source

Per-router packet injection source for the NoC simulation. Holds a queue of packet descriptors (destination, VC, flit count) loaded by the top-level controller. It presents the next flit to inject as a staging-buffer word and advances one flit per `Dequeue` command. One instance sits beside each router and feeds that router's injection input port 0.

## Interface
Parameters:
- `ROUTER_BITS`, default 4: destination router id width.
- `VC_BITS`, default 2: virtual channel id width.
- `NUMFLIT_BITS`, default 4: packet length field width.
- `CNT_BITS`, default 8: total-traffic counter width.
- `DEPTH`, default 16: descriptor queue depth, power of two.
- `DATA_BITS`, default 32: command data width.
- `BUF_BITS`, default 16: staging buffer word width, at least 3+VC_BITS+ROUTER_BITS.

Ports:
- `clk` input 1: the single clock; all state changes on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `op` input 3: command code.
- `data` input DATA_BITS: command operand.
- `done` output 1: all announced traffic has been injected.
- `buffer` output BUF_BITS: current head flit, in staging format.

## Operation
Op codes:
- 0 NOP, 1 Init, 6 Fill, 7 Dequeue.
- Codes 2–5 (router-only ops) and all others behave as NOP.

Data layout:
- Init: `total = data[CNT_BITS-1:0]`.
- Fill: `dst = data[ROUTER_BITS-1:0]`, then `vc` in the next VC_BITS bits, then `num_flit` in the next NUMFLIT_BITS bits.

Buffer layout:
- bit0 BufferFull, bit1 FlitHead, bit2 FlitTail.
- bits [3+VC_BITS-1:3] BufferVc, next ROUTER_BITS bits FlitDst.
- All remaining bits are 0.

Commands:
- **Init:** empties the queue, clears `flit_idx` and `sent`, and loads `total`.
- **Fill:** pushes a descriptor at the tail. If the queue already holds DEPTH entries, the descriptor is dropped and state is unchanged. `num_flit`=0 is stored as 1.
- **Dequeue:** if the queue is non-empty, `flit_idx` increments. On the tail flit, the head descriptor is popped, `flit_idx` returns to 0 and `sent` increments (saturating at all-ones). Dequeue on an empty queue is a no-op.

Buffer contents (combinational from registered state):
- Queue empty: `buffer` = 0.
- Otherwise: Full=1, Head=(`flit_idx`==0), Tail=(`flit_idx`==`num_flit`-1), Vc and Dst taken from the head descriptor.
- A 1-flit packet shows Head=Tail=1.

Done:
- `done` = (`sent` >= `total`) && queue empty.

## Timing
- Reset value: queue empty, `flit_idx`=0, `sent`=0, `total`=0, so `buffer`=0 and `done`=1.
- Reset asserted mid-operation discards all descriptors immediately, asynchronously.
- Every command takes effect at the rising edge where `op` is sampled. `buffer` and `done` reflect the new state in the same cycle after that edge, with no additional latency.
- The controller issues exactly one op per cycle, so there are no simultaneous-event conflicts.
- Dequeue consumes the flit that was visible on `buffer` before the edge. The controller issues Dequeue only when the router's `can_inject` is set for BufferVc.

## Structure
- Shared package: op codes (NOP, Init, LoadRt, LoadStaging, Phase0, Phase1, Fill, Dequeue), data-field and buffer-field offset constants, and width parameters. The router and the top level use the same package.
- One sub-module, `traffic_desc_fifo`: a synchronous DEPTH-entry FIFO of {dst, vc, num_flit} with push, pop, empty, full and head outputs, plus the same async active-low reset.

## Test plan
- **Reset:** after `rst_n` is deasserted with no ops → `buffer`=0, `done`=1.
- **Init and single-flit fill:**
  - Init total=1, then Fill dst=5 vc=2 num_flit=1 → Full=1, Head=1, Tail=1, Vc=2, Dst=5, `done`=0.
  - Then Dequeue → `buffer`=0, `done`=1.
- **Three-flit packet:** Fill dst=3 num_flit=3, then three Dequeues → (Head,Tail) = (1,0), (0,0), (0,1) across the three cycles, then Full=0.
- **Two packets:** Fill A(dst=1, len 2) and B(dst=2, len 1), total=2 → flits appear in order A0, A1, B0. `done` rises only after the B0 Dequeue.
- **Overflow and empty dequeue:**
  - Fill DEPTH+1 descriptors → only the first DEPTH are dequeued; the extra one is dropped.
  - Dequeue on an empty queue → no change, `sent` unchanged.
- **Async reset mid-packet:** `rst_n` low while `flit_idx`=1 → `buffer`=0 without waiting for a clock edge; a following Fill starts with Head=1.

Source files
------------

// File: rtl/traffic_source_pkg.sv
// Shared NoC definitions: command op codes, field offsets and default widths.
// Both the router and the traffic source import this package.
package traffic_source_pkg;

  typedef enum logic [2:0] {
    OpNop         = 3'd0,
    OpInit        = 3'd1,
    OpLoadRt      = 3'd2,
    OpLoadStaging = 3'd3,
    OpPhase0      = 3'd4,
    OpPhase1      = 3'd5,
    OpFill        = 3'd6,
    OpDequeue     = 3'd7
  } op_e;

  localparam int unsigned DefRouterBits  = 4;
  localparam int unsigned DefVcBits      = 2;
  localparam int unsigned DefNumflitBits = 4;
  localparam int unsigned DefCntBits     = 8;
  localparam int unsigned DefDepth       = 16;
  localparam int unsigned DefDataBits    = 32;
  localparam int unsigned DefBufBits     = 16;

  // Staging-buffer word: flag bits, then VC, then destination router.
  localparam int unsigned BufFullBit = 0;
  localparam int unsigned BufHeadBit = 1;
  localparam int unsigned BufTailBit = 2;
  localparam int unsigned BufVcLsb   = 3;

  // Fill operand: destination at bit 0, VC and flit count packed above it.
  localparam int unsigned DataDstLsb = 0;

endpackage

// File: rtl/traffic_desc_fifo.sv
// Synchronous descriptor FIFO with clear; push when full and pop when empty are ignored.
module traffic_desc_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_empty,
  output logic             o_full,
  output logic [WIDTH-1:0] o_head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push_ok;
  logic             w_pop_ok;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok && !i_clear) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/traffic_source.sv
// Per-router packet injection source: queues packet descriptors and presents the
// head flit as a staging-buffer word, advancing one flit per Dequeue.
module traffic_source
  import traffic_source_pkg::*;
#(
  parameter int unsigned ROUTER_BITS  = DefRouterBits,
  parameter int unsigned VC_BITS      = DefVcBits,
  parameter int unsigned NUMFLIT_BITS = DefNumflitBits,
  parameter int unsigned CNT_BITS     = DefCntBits,
  parameter int unsigned DEPTH        = DefDepth,
  parameter int unsigned DATA_BITS    = DefDataBits,
  parameter int unsigned BUF_BITS     = DefBufBits
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2:0]           op,
  input  logic [DATA_BITS-1:0] data,
  output logic                 done,
  output logic [BUF_BITS-1:0]  buffer
);

  localparam int unsigned DescW     = ROUTER_BITS + VC_BITS + NUMFLIT_BITS;
  localparam int unsigned DataVcLsb = DataDstLsb + ROUTER_BITS;
  localparam int unsigned DataNfLsb = DataVcLsb + VC_BITS;
  localparam int unsigned BufDstLsb = BufVcLsb + VC_BITS;

  logic [NUMFLIT_BITS-1:0] r_flit_idx;
  logic [CNT_BITS-1:0]     r_sent;
  logic [CNT_BITS-1:0]     r_total;

  logic                    w_init;
  logic                    w_fill;
  logic                    w_deq;
  logic                    w_empty;
  logic                    w_full;
  logic [DescW-1:0]        w_head;
  logic [DescW-1:0]        w_push_desc;
  logic [NUMFLIT_BITS-1:0] w_fill_nf;
  logic [ROUTER_BITS-1:0]  w_head_dst;
  logic [VC_BITS-1:0]      w_head_vc;
  logic [NUMFLIT_BITS-1:0] w_head_nf;
  logic [NUMFLIT_BITS-1:0] w_last_idx;
  logic                    w_is_tail;
  logic                    w_advance;
  logic                    w_pop;
  logic [BUF_BITS-1:0]     w_buffer;
  logic                    w_unused_data;

  // Router-only op codes fall through to the default and act as NOP here.
  always_comb begin
    w_init = 1'b0;
    w_fill = 1'b0;
    w_deq  = 1'b0;
    case (op_e'(op))
      OpInit:    w_init = 1'b1;
      OpFill:    w_fill = 1'b1;
      OpDequeue: w_deq  = 1'b1;
      default:   ;
    endcase
  end

  assign w_fill_nf   = (data[DataNfLsb +: NUMFLIT_BITS] == '0) ? NUMFLIT_BITS'(1)
                                                             : data[DataNfLsb +: NUMFLIT_BITS];
  assign w_push_desc = {data[DataDstLsb +: ROUTER_BITS], data[DataVcLsb +: VC_BITS], w_fill_nf};
  assign w_unused_data = ^data;

  assign {w_head_dst, w_head_vc, w_head_nf} = w_head;
  assign w_last_idx = w_head_nf - NUMFLIT_BITS'(1);
  assign w_is_tail  = (r_flit_idx == w_last_idx);
  assign w_advance  = w_deq && !w_empty;
  assign w_pop      = w_advance && w_is_tail;

  traffic_desc_fifo #(
    .WIDTH (DescW),
    .DEPTH (DEPTH)
  ) u_desc_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_init),
    .i_push  (w_fill),
    .i_data  (w_push_desc),
    .i_pop   (w_pop),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_head  (w_head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flit_idx <= '0;
      r_sent     <= '0;
      r_total    <= '0;
    end else if (w_init) begin
      r_flit_idx <= '0;
      r_sent     <= '0;
      r_total    <= data[CNT_BITS-1:0];
    end else if (w_advance) begin
      if (w_is_tail) begin
        r_flit_idx <= '0;
        if (r_sent != '1) r_sent <= r_sent + 1'b1;
      end else begin
        r_flit_idx <= r_flit_idx + 1'b1;
      end
    end
  end

  always_comb begin
    w_buffer = '0;
    if (!w_empty) begin
      w_buffer[BufFullBit]                = 1'b1;
      w_buffer[BufHeadBit]                = (r_flit_idx == '0);
      w_buffer[BufTailBit]                = w_is_tail;
      w_buffer[BufVcLsb +: VC_BITS]       = w_head_vc;
      w_buffer[BufDstLsb +: ROUTER_BITS]  = w_head_dst;
    end
  end

  assign buffer = w_buffer;
  assign done   = (r_sent >= r_total) && w_empty;

endmodule

// File: tb/tb_traffic_source.sv
// Scoreboard bench for traffic_source: the driver queues the expected buffer/done
// for every op, and a monitor compares them just after the edge that applies it.
module tb_traffic_source;

  logic        clk;
  logic        rst_n;
  logic [2:0]  op;
  logic [31:0] data;
  logic        done;
  logic [15:0] buffer;

  typedef struct {
    logic [15:0] buf_w;
    logic        done_b;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  traffic_source dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .op     (op),
    .data   (data),
    .done   (done),
    .buffer (buffer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, required to finish", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] mkbuf(input int head, input int tail, input int vc,
                                        input int dst);
    logic [15:0] b;
    b = 16'(1 | (head << 1) | (tail << 2) | (vc << 3) | (dst << 5));
    return b;
  endfunction

  function automatic logic [31:0] mkdata(input int dst, input int vc, input int nf);
    return 32'(dst | (vc << 4) | (nf << 6));
  endfunction

  task automatic chk(input string name, input logic [15:0] act_b, input logic [15:0] exp_b,
                     input logic act_d, input logic exp_d);
    n_checks++;
    if (act_b === exp_b && act_d === exp_d) n_pass++;
    else $display("FAIL %s: buffer=%h done=%b, required buffer=%h done=%b",
                  name, act_b, act_d, exp_b, exp_d);
  endtask

  // Monitor: the op driven at the preceding negedge has been applied by this edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.name, buffer, e.buf_w, done, e.done_b);
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] d, input logic [15:0] eb,
                       input logic ed, input string name);
    exp_t e;
    @(negedge clk);
    op   = o;
    data = d;
    e.buf_w  = eb;
    e.done_b = ed;
    e.name   = name;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    @(negedge clk);
    op   = 3'd0;
    data = '0;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    op    = 3'd0;
    data  = '0;
    #12;
    chk("reset_in", buffer, 16'h0, done, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    issue(3'd0, 32'h0, 16'h0, 1'b1, "reset_nop");
    issue(3'd3, 32'h3ff, 16'h0, 1'b1, "router_op_nop");

    // Single-flit packet
    issue(3'd1, 32'd1, 16'h0, 1'b0, "init1");
    issue(3'd6, mkdata(5, 2, 1), mkbuf(1, 1, 2, 5), 1'b0, "fill_single");
    issue(3'd7, 32'h0, 16'h0, 1'b1, "deq_single");

    // Three-flit packet
    issue(3'd1, 32'd1, 16'h0, 1'b0, "init3");
    issue(3'd6, mkdata(3, 0, 3), mkbuf(1, 0, 0, 3), 1'b0, "fill3_f0");
    issue(3'd7, 32'h0, mkbuf(0, 0, 0, 3), 1'b0, "p3_f1");
    issue(3'd7, 32'h0, mkbuf(0, 1, 0, 3), 1'b0, "p3_f2");
    issue(3'd7, 32'h0, 16'h0, 1'b1, "p3_empty");

    // Two packets in order
    issue(3'd1, 32'd2, 16'h0, 1'b0, "init2");
    issue(3'd6, mkdata(1, 1, 2), mkbuf(1, 0, 1, 1), 1'b0, "fillA");
    issue(3'd6, mkdata(2, 3, 1), mkbuf(1, 0, 1, 1), 1'b0, "fillB");
    issue(3'd7, 32'h0, mkbuf(0, 1, 1, 1), 1'b0, "A1");
    issue(3'd7, 32'h0, mkbuf(1, 1, 3, 2), 1'b0, "B0");
    issue(3'd7, 32'h0, 16'h0, 1'b1, "two_done");

    // Overflow: 17 fills of length-0 (stored as 1) descriptors, 16 come back
    issue(3'd1, 32'd0, 16'h0, 1'b1, "init0");
    for (int i = 0; i < 17; i++)
      issue(3'd6, mkdata(i % 16, i % 4, 0), mkbuf(1, 1, 0, 0), 1'b0, "ovf_fill");
    for (int k = 1; k < 16; k++)
      issue(3'd7, 32'h0, mkbuf(1, 1, k % 4, k), 1'b0, "ovf_deq");
    issue(3'd7, 32'h0, 16'h0, 1'b1, "ovf_last");
    issue(3'd7, 32'h0, 16'h0, 1'b1, "ovf_extra_empty");

    // Dequeue on empty must not count as sent
    issue(3'd1, 32'd1, 16'h0, 1'b0, "init_empty");
    issue(3'd7, 32'h0, 16'h0, 1'b0, "deq_empty_nosent");
    issue(3'd6, mkdata(4, 1, 1), mkbuf(1, 1, 1, 4), 1'b0, "fill_after_empty");
    issue(3'd7, 32'h0, 16'h0, 1'b1, "deq_after_empty");

    // Async reset mid-packet
    issue(3'd1, 32'd1, 16'h0, 1'b0, "init_ar");
    issue(3'd6, mkdata(7, 1, 2), mkbuf(1, 0, 1, 7), 1'b0, "ar_fill");
    issue(3'd7, 32'h0, mkbuf(0, 1, 1, 7), 1'b0, "ar_f1");
    drain();
    rst_n = 1'b0;
    #1;
    chk("async_reset", buffer, 16'h0, done, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    issue(3'd6, mkdata(7, 1, 2), mkbuf(1, 0, 1, 7), 1'b0, "post_reset_fill");
    drain();

    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
